// File: rtl/zb_chip_spreader_if.sv
// Bundle between the output FIFO and the 802.15.4 chip spreader.
// With ZB_SPREADER_IQ_SPLIT_EN defined the bundle also carries the I/Q chip rails.
interface zb_chip_spreader_if;
    logic       inEnable;
    logic       inEmpty;
    logic [3:0] inSymbol;
    logic       outReadEnable;
    logic       outChip;
    logic       outChipValid;
    logic       outChipStrobe;
    logic       outSymbolDone;
    logic       outBusy;
`ifdef ZB_SPREADER_IQ_SPLIT_EN
    logic       outChipI;
    logic       outChipQ;
`endif

`ifdef ZB_SPREADER_IQ_SPLIT_EN
    modport slave (
        input  inEnable, inEmpty, inSymbol,
        output outReadEnable, outChip, outChipValid, outChipStrobe,
               outSymbolDone, outBusy, outChipI, outChipQ
    );
    modport master (
        output inEnable, inEmpty, inSymbol,
        input  outReadEnable, outChip, outChipValid, outChipStrobe,
               outSymbolDone, outBusy, outChipI, outChipQ
    );
`else
    modport slave (
        input  inEnable, inEmpty, inSymbol,
        output outReadEnable, outChip, outChipValid, outChipStrobe,
               outSymbolDone, outBusy
    );
    modport master (
        output inEnable, inEmpty, inSymbol,
        input  outReadEnable, outChip, outChipValid, outChipStrobe,
               outSymbolDone, outBusy
    );
`endif
endinterface

// File: rtl/zb_chip_spreader.sv
// IEEE 802.15.4 (2.4 GHz) symbol-to-chip spreader.
// Pops 4-bit symbols from the output FIFO and emits the 32-chip PN sequence
// serially, one chip per CHIP_DIV clocks, gapless across back-to-back symbols
// thanks to a one-symbol prefetch into a hold register.
// Optional build macro: ZB_SPREADER_IQ_SPLIT_EN adds outChipI/outChipQ rails
// for the O-QPSK modulator (even chips on I, odd chips on Q).
module zb_chip_spreader #(
    parameter int CHIP_DIV = 4
) (
    input  logic               inClock,
    input  logic               inReset,
    zb_chip_spreader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CAPT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    // Symbol 0 sequence, stored with c0 in bit 31 so chips leave from the MSB.
    localparam logic [31:0] SYM0_CHIPS = 32'b1101_1001_1100_0011_0101_0010_0010_1110;
    localparam logic [7:0]  DIV_LAST   = 8'(CHIP_DIV - 1);

    if (CHIP_DIV < 2 || CHIP_DIV > 255) begin : g_bad_chip_div
        $error("zb_chip_spreader: CHIP_DIV must be in 2..255");
    end

    // Symbol k (k<8) is symbol 0 rotated right by 4k chips; k>=8 also flips odd chips.
    function automatic logic [31:0] map_symbol(input logic [3:0] sym);
        logic [63:0] doubled;
        logic [31:0] chips;
        doubled = {SYM0_CHIPS, SYM0_CHIPS} >> {sym[2:0], 2'b00};
        chips   = doubled[31:0];
        if (sym[3]) begin
            chips = chips ^ 32'h5555_5555;
        end else begin
            chips = chips;
        end
        return chips;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] shift_r, shift_s;
    logic [31:0] hold_r, hold_s;
    logic        hold_valid_r, hold_valid_s;
    logic [4:0]  idx_r, idx_s;
    logic [7:0]  div_r, div_s;
    logic        rd_s;
    logic        rd_r;
    logic        cap_r;
    logic        chip_r, valid_r, strobe_r, done_r, busy_r;
`ifdef ZB_SPREADER_IQ_SPLIT_EN
    logic        chip_i_r, chip_q_r;
`endif

    // Next-state, datapath and fetch decisions for the spreader FSM.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        idx_s        = idx_r;
        div_s        = div_r;
        rd_s         = 1'b0;

        // Prefetched symbol arrives the cycle after its pop pulse.
        if (cap_r) begin
            hold_s       = map_symbol(bus.inSymbol);
            hold_valid_s = 1'b1;
        end else begin
            hold_s       = hold_r;
        end

        case (state_r)
            IDLE: begin
                if (bus.inEnable && !bus.inEmpty) begin
                    state_s = REQ;
                    rd_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                state_s = CAPT;
            end
            CAPT: begin
                shift_s = map_symbol(bus.inSymbol);
                idx_s   = 5'd0;
                div_s   = 8'd0;
                state_s = SHIFT;
            end
            SHIFT: begin
                if (idx_r == 5'd30 && div_r == 8'd0 && bus.inEnable && !bus.inEmpty) begin
                    rd_s = 1'b1;
                end else begin
                    rd_s = 1'b0;
                end
                if (div_r == DIV_LAST) begin
                    div_s = 8'd0;
                    if (idx_r == 5'd31) begin
                        idx_s = 5'd0;
                        if (hold_valid_r) begin
                            shift_s      = hold_r;
                            hold_valid_s = 1'b0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        idx_s   = idx_r + 5'd1;
                        shift_s = {shift_r[30:0], 1'b0};
                    end
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any symbol in flight.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_r      <= IDLE;
            shift_r      <= 32'd0;
            hold_r       <= 32'd0;
            hold_valid_r <= 1'b0;
            idx_r        <= 5'd0;
            div_r        <= 8'd0;
            rd_r         <= 1'b0;
            cap_r        <= 1'b0;
            chip_r       <= 1'b0;
            valid_r      <= 1'b0;
            strobe_r     <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
`ifdef ZB_SPREADER_IQ_SPLIT_EN
            chip_i_r     <= 1'b0;
            chip_q_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            idx_r        <= idx_s;
            div_r        <= div_s;
            rd_r         <= rd_s;
            cap_r        <= rd_r && (state_r == SHIFT);
            chip_r       <= (state_s == SHIFT) && shift_s[31];
            valid_r      <= (state_s == SHIFT);
            strobe_r     <= (state_s == SHIFT) && (div_s == 8'd0);
            done_r       <= (state_s == SHIFT) && (idx_s == 5'd31) && (div_s == DIV_LAST);
            busy_r       <= (state_s != IDLE);
`ifdef ZB_SPREADER_IQ_SPLIT_EN
            if (state_s != SHIFT) begin
                chip_i_r <= 1'b0;
                chip_q_r <= 1'b0;
            end else if (div_s == 8'd0) begin
                if (!idx_s[0]) begin
                    chip_i_r <= shift_s[31];
                end else begin
                    chip_q_r <= shift_s[31];
                end
            end
`endif
        end
    end

    assign bus.outReadEnable = rd_r;
    assign bus.outChip       = chip_r;
    assign bus.outChipValid  = valid_r;
    assign bus.outChipStrobe = strobe_r;
    assign bus.outSymbolDone = done_r;
    assign bus.outBusy       = busy_r;
`ifdef ZB_SPREADER_IQ_SPLIT_EN
    assign bus.outChipI      = chip_i_r;
    assign bus.outChipQ      = chip_q_r;
`endif

endmodule
